// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Pipeline hazard and stall controller. It arbitrates between three sources
// that want to hold or clear the pipeline:
//   * flush requests (exception / redirect), which clear every stage,
//   * multicycle EX operations, which hold PC/IF/ID/EX until the result is
//     ready,
//   * ID load-use hazards, which hold PC/IF/ID for one cycle at a time.
// The priority is flush > EX stall > ID stall. Only one encoding is ever
// driven in a given cycle.
//
// The controller also keeps a saturating count of the cycles in which any
// stall bit was set.
//
// Parameters
//   CYC_W         width of the multicycle length field
//   CNT_W         width of the stall-cycle counter
//
// Ports
//   clk           pipeline clock; all state updates on its rising edge
//   rst           synchronous active-low reset
//   stallreq_id   ID load-use hazard request (level)
//   ex_mc_start   one-cycle pulse: EX begins a multicycle op
//   ex_mc_cycles  total EX occupancy in cycles, sampled with ex_mc_start
//   ex_mc_cancel  abort the running multicycle op
//   flush_req     pipeline flush request
//   stat_clr      clear the stall counter
//   stall         per-stage hold {wb, mem, ex, id, if, pc}; 1 = hold
//   flush         flush all stage registers this cycle
//   ex_mc_done    one-cycle pulse: multicycle result valid in EX
//   busy          multicycle op in progress
//   stall_cnt     saturating count of cycles with stall != 0
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no multicycle op pending; ID stalls and new ops are accepted
// MC_RUN | multicycle op running; rem holds the stall cycles still to go
// ----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int CYC_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_start,
    input  logic [CYC_W-1:0] ex_mc_cycles,
    input  logic             ex_mc_cancel,
    input  logic             flush_req,
    input  logic             stat_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             ex_mc_done,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MC_RUN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CYC_W-1:0] rem;
    logic [CYC_W-1:0] rem_nxt;

    logic             ex_stall;
    logic             id_stall;
    logic             flush_c;
    logic             done_c;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        ex_stall  = 1'b0;
        id_stall  = 1'b0;
        flush_c   = 1'b0;
        done_c    = 1'b0;

        if (!rst) begin
            // Outputs stay at their zero defaults while reset is low; the
            // register block clears state on the edge.
            state_nxt = IDLE;
            rem_nxt   = '0;
        end else if (flush_req) begin
            // A flush discards any running op, including one finishing now.
            flush_c   = 1'b1;
            state_nxt = IDLE;
            rem_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // An op of N cycles needs N-1 stall cycles. This cycle is
                    // the first one, so rem starts at N-2. Ops shorter than
                    // two cycles complete in the normal pipeline slot.
                    if (ex_mc_start && (ex_mc_cycles >= CYC_W'(2))) begin
                        ex_stall  = 1'b1;
                        rem_nxt   = ex_mc_cycles - CYC_W'(2);
                        state_nxt = MC_RUN;
                    end
                end
                MC_RUN: begin
                    if (ex_mc_cancel) begin
                        state_nxt = IDLE;
                        rem_nxt   = '0;
                    end else if (rem != '0) begin
                        ex_stall = 1'b1;
                        rem_nxt  = rem - CYC_W'(1);
                    end else begin
                        done_c    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                end
            endcase

            // A load-use hazard is only visible when EX is not already
            // holding the front of the pipe.
            id_stall = stallreq_id && !ex_stall;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        stall = STALL_NONE;
        if (ex_stall) begin
            stall = STALL_EX;
        end else if (id_stall) begin
            stall = STALL_ID;
        end
    end

    assign flush      = flush_c;
    assign ex_mc_done = done_c;
    // Gated with rst so busy reads 0 during the reset cycle itself.
    assign busy       = rst && (state == MC_RUN);

    // ------------------------------------------------------------------------
    // Stall-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if ((stall != STALL_NONE) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-low reset: clk and rst; rst low at a rising clk edge resets, asynchronous rst changes have no effect.
REQ-002 Parameter CYC_W, default 6, SHALL set the width of the multicycle length field.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the stall-cycle counter.
REQ-004 clk  input  1  pipeline clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 stallreq_id  input  1  ID load-use hazard request, level.
REQ-007 ex_mc_start  input  1  single-cycle pulse: EX begins a multicycle op.
REQ-008 ex_mc_cycles  input  CYC_W  total EX occupancy in cycles, sampled with ex_mc_start.
REQ-009 ex_mc_cancel  input  1  abort the running multicycle op.
REQ-010 flush_req  input  1  pipeline flush request (exception/redirect).
REQ-011 stat_clr  input  1  clear the stall counter.
REQ-012 stall  output  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold stage.
REQ-013 flush  output  1  flush all stage registers this cycle.
REQ-014 ex_mc_done  output  1  one-cycle pulse: multicycle result valid in EX.
REQ-015 busy  output  1  multicycle op in progress.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with stall != 0.

Function
REQ-017 The FSM SHALL have two states: IDLE and MC_RUN, plus a CYC_W-bit remaining-cycles register rem.
REQ-018 In IDLE with ex_mc_start=1, ex_mc_cycles=N>=2, no flush_req: stall SHALL be 6'b001111 that cycle, rem SHALL load N-2, and the next state SHALL be MC_RUN.
REQ-019 ex_mc_start with N<2 SHALL be treated as single-cycle: no stall, no state change, no ex_mc_done.
REQ-020 In MC_RUN with rem!=0: stall SHALL be 6'b001111, rem SHALL decrement by 1, and the state SHALL remain MC_RUN.
REQ-021 In MC_RUN with rem==0: ex_mc_done SHALL be 1, stall[3] SHALL be 0, and the next state SHALL be IDLE; an op of N cycles stalls exactly N-1 cycles.
REQ-022 ex_mc_start in MC_RUN SHALL be ignored.
REQ-023 ex_mc_cancel in MC_RUN SHALL deassert the EX stall in that same cycle, suppress ex_mc_done, and return the FSM to IDLE; ex_mc_cancel in IDLE SHALL be ignored.
REQ-024 ID stall (stall=6'b000111) SHALL be asserted when stallreq_id=1 and no EX stall or flush is active that cycle.
REQ-025 flush_req SHALL have top priority: flush=1 combinationally, stall=0, ex_mc_done=0 in that cycle, the FSM SHALL return to IDLE, and any running op SHALL be discarded.
REQ-026 Priority SHALL be flush > EX stall > ID stall; the outputs SHALL never carry a mix of encodings.
REQ-027 busy SHALL equal (state==MC_RUN).
REQ-028 stall_cnt SHALL increment on each clock edge where stall!=0, saturate at all ones, and load 0 when stat_clr=1; stat_clr SHALL win over increment.
REQ-029 stall, flush and ex_mc_done SHALL be combinational from state and inputs; no additional latency is permitted.

Reset
REQ-030 In any cycle with rst=0, the outputs SHALL be forced to stall=0, flush=0, ex_mc_done=0 and busy=0, regardless of other inputs.
REQ-031 At the reset edge, state SHALL become IDLE, rem 0 and stall_cnt 0.
REQ-032 Reset asserted mid-MC_RUN SHALL abort the op with no ex_mc_done.

Verification
REQ-033 ex_mc_start, N=5 at cycle T -> stall=001111 in T..T+3, ex_mc_done=1 and stall=0 at T+4, busy=1 in T+1..T+4, stall_cnt=4.
REQ-034 N=2 -> one stall cycle at T, done at T+1; N=1 and N=0 -> no stall, no done, busy stays 0.
REQ-035 N=10, ex_mc_cancel at T+3 -> stall=0 at T+3, no done ever, busy=0 from T+4; stallreq_id=1 throughout -> stall=000111 from T+3.
REQ-036 N=6 with flush_req at T+2 -> flush=1, stall=0 at T+2, IDLE at T+3, no done; concurrent stallreq_id=1 -> still stall=0 at T+2.
REQ-037 stall_cnt preset near saturation via repeated stalls -> holds all ones; stat_clr together with a stall cycle -> 0.
REQ-038 rst=0 during MC_RUN with ex_mc_start and flush_req high -> all outputs 0 in the reset cycle; after release, state IDLE, stall_cnt=0.
